// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed RAM plus four MMIO words on the core's DMEM port.
// Define DMEM_INIT_SWEEP_EN to zero-fill RAM after reset before accepting accesses.
module dmem_responder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1 << ADDR_W,
    parameter int GPIO_W = 8
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [ADDR_W-1:0] address_DMEM,
    input  logic [31:0]       write_data_DMEM,
    input  logic              MemWrite,
    input  logic              MemRead,
    output logic [31:0]       data_DMEM,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq,
    output logic              ready
);

    localparam int T = DEPTH - 4;

    localparam logic [ADDR_W-1:0] A_GPIO = ADDR_W'(T);
    localparam logic [ADDR_W-1:0] A_CNT  = ADDR_W'(T + 1);
    localparam logic [ADDR_W-1:0] A_CMP  = ADDR_W'(T + 2);
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(T + 3);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(T - 1);

    logic [31:0]       mem [0:T-1];

    logic [GPIO_W-1:0] gpio_q;
    logic [31:0]       cnt_q;
    logic [31:0]       cmp_q;
    logic              match_q;
    logic              irq_en_q;
    logic              err_q;
    logic              irq_q;
    logic              ready_q;
    logic              sweeping;

    logic              is_ram;
    logic              is_gpio;
    logic              is_cnt;
    logic              is_cmp;
    logic              is_stat;

    logic              rd_ok;
    logic              wr_ok;
    logic              conflict;
    logic              stat_wr;
    logic              cnt_hit;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_wa;
    logic [31:0]       ram_wd;
    logic [31:0]       rd_word;

    assign is_ram  = address_DMEM < A_GPIO;
    assign is_gpio = address_DMEM == A_GPIO;
    assign is_cnt  = address_DMEM == A_CNT;
    assign is_cmp  = address_DMEM == A_CMP;
    assign is_stat = address_DMEM == A_STAT;

    assign rd_ok    = MemRead & ~MemWrite & ready_q;
    assign wr_ok    = MemWrite & ~MemRead & ready_q;
    assign conflict = MemRead & MemWrite;
    assign stat_wr  = wr_ok & is_stat;
    assign cnt_hit  = cnt_q == cmp_q;

`ifdef DMEM_INIT_SWEEP_EN
    typedef enum logic {
        S_SWEEP,
        S_READY
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;

    // Post-reset sweep: zero one RAM word per cycle, then open the port
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_SWEEP;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_SWEEP: begin
                    if (ptr_q == A_LAST) begin
                        state_q <= S_READY;
                        ready_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                S_READY: begin
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign sweeping = state_q == S_SWEEP;
    assign ram_wa   = sweeping ? ptr_q : address_DMEM;
`else
    // Port opens on the first edge after reset release
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign sweeping = 1'b0;
    assign ram_wa   = address_DMEM;
`endif

    assign ram_we = sweeping | (wr_ok & is_ram);
    assign ram_wd = sweeping ? 32'd0 : write_data_DMEM;

    // RAM array: no reset, one write port shared by core and sweep
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            mem[ram_wa] <= ram_wd;
        end
    end

    // GPIO output register keeps only the low GPIO_W bits
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            gpio_q <= '0;
        end else if (wr_ok && is_gpio) begin
            gpio_q <= write_data_DMEM[GPIO_W-1:0];
        end
    end

    // Free-running counter; a store loads instead of incrementing
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q <= 32'd0;
        end else if (wr_ok && is_cnt) begin
            cnt_q <= write_data_DMEM;
        end else begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    // Timer compare value
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cmp_q <= 32'hFFFF_FFFF;
        end else if (wr_ok && is_cmp) begin
            cmp_q <= write_data_DMEM;
        end
    end

    // Status flags: hardware set beats software W1C
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            match_q  <= 1'b0;
            irq_en_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (cnt_hit) begin
                match_q <= 1'b1;
            end else if (stat_wr && write_data_DMEM[0]) begin
                match_q <= 1'b0;
            end
            if (conflict) begin
                err_q <= 1'b1;
            end else if (stat_wr && write_data_DMEM[2]) begin
                err_q <= 1'b0;
            end
            if (stat_wr) begin
                irq_en_q <= write_data_DMEM[1];
            end
        end
    end

    // Interrupt line follows the status bits one cycle later
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= match_q & irq_en_q;
        end
    end

    // Read mux over RAM and MMIO words, pre-write state
    always_comb begin
        rd_word = 32'd0;
        unique case (1'b1)
            is_gpio: rd_word = 32'(gpio_q);
            is_cnt:  rd_word = cnt_q;
            is_cmp:  rd_word = cmp_q;
            is_stat: rd_word = {29'd0, err_q, irq_en_q, match_q};
            default: rd_word = mem[address_DMEM];
        endcase
    end

    assign data_DMEM = rd_ok ? rd_word : 32'd0;
    assign gpio_out  = gpio_q;
    assign irq       = irq_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder.
// Covers RAM, MMIO registers, timer irq, conflicts, reset and optional sweep.
module tb_dmem_responder;

    localparam int T = (1 << 10) - 4;

    localparam logic [9:0] A_GPIO = 10'd1020;
    localparam logic [9:0] A_CNT  = 10'd1021;
    localparam logic [9:0] A_CMP  = 10'd1022;
    localparam logic [9:0] A_STAT = 10'd1023;

`ifdef DMEM_INIT_SWEEP_EN
    localparam int          EXP_RDY = T;
    localparam logic [31:0] W9_EXP  = 32'h0;
`else
    localparam int          EXP_RDY = 1;
    localparam logic [31:0] W9_EXP  = 32'hA5A5_0009;
`endif

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic [9:0]  address_DMEM = '0;
    logic [31:0] write_data_DMEM = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] data_DMEM;
    logic [7:0]  gpio_out;
    logic        irq;
    logic        ready;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sbq [$];
    logic [31:0] exp;

    dmem_responder #(
        .ADDR_W(10),
        .GPIO_W(8)
    ) dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .address_DMEM   (address_DMEM),
        .write_data_DMEM(write_data_DMEM),
        .MemWrite       (MemWrite),
        .MemRead        (MemRead),
        .data_DMEM      (data_DMEM),
        .gpio_out       (gpio_out),
        .irq            (irq),
        .ready          (ready)
    );

    always #5 CLK = ~CLK;

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        MemWrite = 1'b0;
        MemRead  = 1'b0;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        address_DMEM    = a;
        write_data_DMEM = d;
        MemWrite        = 1'b1;
        MemRead         = 1'b0;
        step();
        idle();
    endtask

    task automatic rd(input logic [9:0] a);
        address_DMEM = a;
        MemRead      = 1'b1;
        MemWrite     = 1'b0;
        @(negedge CLK);
    endtask

    task automatic release_and_wait(output int n);
        RSTn = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (ready !== 1'b1 && n < 3000);
    endtask

    task automatic test_reset();
        int n;
        logic [9:0] addrs [4];
        idle();
        RSTn = 1'b0;
        repeat (3) step();
        rd(A_CMP);
        checks++;
        if (ready !== 1'b0 || gpio_out !== 8'h0 || irq !== 1'b0 || data_DMEM !== 32'h0) begin
            errors++;
            $display("FAIL rst_hold ready=%b gpio=%h irq=%b data=%h exp 0/00/0/0",
                     ready, gpio_out, irq, data_DMEM);
        end
        idle();
        step();
        release_and_wait(n);
        checks++;
        if (n != EXP_RDY) begin
            errors++;
            $display("FAIL rst_ready_lat got=%0d exp=%0d", n, EXP_RDY);
        end
        addrs = '{A_CNT, A_CMP, A_STAT, A_GPIO};
        sbq.push_back(32'(n));
        sbq.push_back(32'h0000_0001 + 32'hFFFF_FFFE);
        sbq.push_back(32'h0);
        sbq.push_back(32'h0);
        foreach (addrs[i]) begin
            rd(addrs[i]);
            exp = sbq.pop_front();
            checks++;
            if (data_DMEM !== exp) begin
                errors++;
                $display("FAIL rst_val addr=%0d got=%h exp=%h", addrs[i], data_DMEM, exp);
            end
            idle();
            step();
        end
    endtask

    task automatic test_ram();
        logic [9:0]  addrs [5];
        logic [31:0] d;
        wr(10'd5, 32'hDEAD_BEEF);
        sbq.push_back(32'hDEAD_BEEF);
        rd(10'd5);
        exp = sbq.pop_front();
        checks++;
        if (data_DMEM !== exp) begin
            errors++;
            $display("FAIL ram_w5 got=%h exp=%h", data_DMEM, exp);
        end
        idle();
        step();
        addrs = '{10'd0, 10'd5, 10'd300, 10'd511, 10'(T - 1)};
        foreach (addrs[i]) begin
            d = $urandom();
            wr(addrs[i], d);
            sbq.push_back(d);
        end
        foreach (addrs[i]) begin
            rd(addrs[i]);
            exp = sbq.pop_front();
            checks++;
            if (data_DMEM !== exp) begin
                errors++;
                $display("FAIL ram_rd addr=%0d got=%h exp=%h", addrs[i], data_DMEM, exp);
            end
            idle();
            step();
        end
    endtask

    task automatic test_irq();
        wr(A_CNT, 32'd0);
        wr(A_CMP, 32'd20);
        wr(A_STAT, 32'd2);
        sbq.push_back(32'd2);
        rd(A_STAT);
        exp = sbq.pop_front();
        checks++;
        if (data_DMEM !== exp || irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_en stat=%h irq=%b exp stat=%h irq=0", data_DMEM, irq, exp);
        end
        idle();
        step();
        repeat (17) step();
        sbq.push_back(32'd2);
        rd(A_STAT);
        exp = sbq.pop_front();
        checks++;
        if (data_DMEM !== exp) begin
            errors++;
            $display("FAIL match_early got=%h exp=%h", data_DMEM, exp);
        end
        idle();
        step();
        sbq.push_back(32'd3);
        rd(A_STAT);
        exp = sbq.pop_front();
        checks++;
        if (data_DMEM !== exp || irq !== 1'b0) begin
            errors++;
            $display("FAIL match_set stat=%h irq=%b exp stat=%h irq=0", data_DMEM, irq, exp);
        end
        idle();
        step();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_rise got=%b exp=1", irq);
        end
        wr(A_STAT, 32'd3);
        sbq.push_back(32'd2);
        rd(A_STAT);
        exp = sbq.pop_front();
        checks++;
        if (data_DMEM !== exp || irq !== 1'b1) begin
            errors++;
            $display("FAIL match_w1c stat=%h irq=%b exp stat=%h irq=1", data_DMEM, irq, exp);
        end
        idle();
        step();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_fall got=%b exp=0", irq);
        end
        wr(A_CNT, 32'd1000);
        wr(A_CMP, 32'd1001);
        wr(A_STAT, 32'd1);
        sbq.push_back(32'd1);
        rd(A_STAT);
        exp = sbq.pop_front();
        checks++;
        if (data_DMEM !== exp) begin
            errors++;
            $display("FAIL match_set_wins got=%h exp=%h", data_DMEM, exp);
        end
        idle();
        step();
        wr(A_STAT, 32'd1);
        sbq.push_back(32'd0);
        rd(A_STAT);
        exp = sbq.pop_front();
        checks++;
        if (data_DMEM !== exp) begin
            errors++;
            $display("FAIL match_clear got=%h exp=%h", data_DMEM, exp);
        end
        idle();
        step();
        wr(A_CMP, 32'h8000_0000);
    endtask

    task automatic test_cnt_wrap();
        wr(A_CNT, 32'hFFFF_FFFE);
        sbq.push_back(32'hFFFF_FFFE);
        sbq.push_back(32'hFFFF_FFFF);
        sbq.push_back(32'h0000_0000);
        sbq.push_back(32'h0000_0001);
        for (int i = 0; i < 4; i++) begin
            rd(A_CNT);
            exp = sbq.pop_front();
            checks++;
            if (data_DMEM !== exp) begin
                errors++;
                $display("FAIL cnt_wrap step=%0d got=%h exp=%h", i, data_DMEM, exp);
            end
            idle();
            step();
        end
    endtask

    task automatic test_conflict();
        wr(A_STAT, 32'd5);
        wr(10'd7, 32'h0000_55AA);
        address_DMEM    = 10'd7;
        write_data_DMEM = 32'd1234;
        MemWrite        = 1'b1;
        MemRead         = 1'b0;
        @(negedge CLK);
        checks++;
        if (data_DMEM !== 32'h0) begin
            errors++;
            $display("FAIL wr_only_data got=%h exp=0", data_DMEM);
        end
        MemRead = 1'b1;
        #1;
        checks++;
        if (data_DMEM !== 32'h0) begin
            errors++;
            $display("FAIL conflict_data got=%h exp=0", data_DMEM);
        end
        step();
        idle();
        sbq.push_back(32'h0000_55AA);
        sbq.push_back(32'h0000_0004);
        rd(10'd7);
        exp = sbq.pop_front();
        checks++;
        if (data_DMEM !== exp) begin
            errors++;
            $display("FAIL conflict_ram got=%h exp=%h", data_DMEM, exp);
        end
        idle();
        step();
        rd(A_STAT);
        exp = sbq.pop_front();
        checks++;
        if (data_DMEM !== exp) begin
            errors++;
            $display("FAIL err_set got=%h exp=%h", data_DMEM, exp);
        end
        idle();
        step();
        wr(A_STAT, 32'd4);
        sbq.push_back(32'h0);
        rd(A_STAT);
        exp = sbq.pop_front();
        checks++;
        if (data_DMEM !== exp) begin
            errors++;
            $display("FAIL err_clear got=%h exp=%h", data_DMEM, exp);
        end
        idle();
        step();
    endtask

    task automatic test_gpio_reset();
        int n;
        logic [9:0] addrs [4];
        wr(A_GPIO, 32'h0000_01FF);
        sbq.push_back(32'h0000_00FF);
        rd(A_GPIO);
        exp = sbq.pop_front();
        checks++;
        if (data_DMEM !== exp || gpio_out !== 8'hFF) begin
            errors++;
            $display("FAIL gpio_wr rd=%h pin=%h exp rd=%h pin=ff", data_DMEM, gpio_out, exp);
        end
        idle();
        step();
        wr(A_CMP, 32'd1234);
        wr(10'd9, 32'hA5A5_0009);
        address_DMEM    = 10'd9;
        write_data_DMEM = 32'h0000_0BAD;
        MemWrite        = 1'b1;
        RSTn            = 1'b0;
        #1;
        checks++;
        if (gpio_out !== 8'h0 || ready !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL async_rst gpio=%h ready=%b irq=%b exp 00/0/0", gpio_out, ready, irq);
        end
        step();
        idle();
        release_and_wait(n);
        checks++;
        if (n != EXP_RDY) begin
            errors++;
            $display("FAIL rst2_ready_lat got=%0d exp=%0d", n, EXP_RDY);
        end
        addrs = '{A_CMP, A_GPIO, A_STAT, 10'd9};
        sbq.push_back(32'hFFFF_FFFF);
        sbq.push_back(32'h0);
        sbq.push_back(32'h0);
        sbq.push_back(W9_EXP);
        foreach (addrs[i]) begin
            rd(addrs[i]);
            exp = sbq.pop_front();
            checks++;
            if (data_DMEM !== exp) begin
                errors++;
                $display("FAIL rst2_val addr=%0d got=%h exp=%h", addrs[i], data_DMEM, exp);
            end
            idle();
            step();
        end
    endtask

`ifdef DMEM_INIT_SWEEP_EN
    task automatic test_sweep();
        int n;
        int busy_bad;
        logic [9:0] addrs [3];
        busy_bad = 0;
        idle();
        RSTn = 1'b0;
        step();
        RSTn = 1'b1;
        n = 0;
        repeat (10) begin
            step();
            n++;
            if (ready !== 1'b0) busy_bad++;
        end
        wr(10'd3, 32'h0000_ABCD);
        n++;
        wr(A_GPIO, 32'h0000_00FF);
        n++;
        rd(A_CMP);
        checks++;
        if (data_DMEM !== 32'h0) begin
            errors++;
            $display("FAIL sweep_rd got=%h exp=0", data_DMEM);
        end
        idle();
        step();
        n++;
        while (n < 100) begin
            step();
            n++;
            if (ready !== 1'b0) busy_bad++;
        end
        checks++;
        if (busy_bad != 0 || gpio_out !== 8'h0) begin
            errors++;
            $display("FAIL sweep_busy bad=%0d gpio=%h exp 0/00", busy_bad, gpio_out);
        end
        RSTn = 1'b0;
        step();
        release_and_wait(n);
        checks++;
        if (n != T) begin
            errors++;
            $display("FAIL sweep_restart_len got=%0d exp=%0d", n, T);
        end
        addrs = '{10'd0, 10'd3, 10'(T - 1)};
        foreach (addrs[i]) sbq.push_back(32'h0);
        foreach (addrs[i]) begin
            rd(addrs[i]);
            exp = sbq.pop_front();
            checks++;
            if (data_DMEM !== exp) begin
                errors++;
                $display("FAIL sweep_zero addr=%0d got=%h exp=%h", addrs[i], data_DMEM, exp);
            end
            idle();
            step();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ram();
        test_irq();
        test_cnt_wrap();
        test_conflict();
        test_gpio_reset();
`ifdef DMEM_INIT_SWEEP_EN
        test_sweep();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
